// File: rtl/vga_sync_porch_gen.sv
// VGA timing generator: column/row counters, sync/active decode, and a pipeline
// that aligns sync, data-enable and frame-start with video from a latent pixel source.
module vga_sync_porch_gen #(
  parameter int VIDEO_WIDTH     = 3,
  parameter int CNT_WIDTH       = 10,
  parameter int ACTIVE_COLS     = 640,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK_PORCH    = 48,
  parameter int ACTIVE_ROWS     = 480,
  parameter int V_FRONT_PORCH   = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK_PORCH    = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int VIDEO_DELAY     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [CNT_WIDTH-1:0]   col_o,
  output logic [CNT_WIDTH-1:0]   row_o,
  input  logic [VIDEO_WIDTH-1:0] red_video_i,
  input  logic [VIDEO_WIDTH-1:0] grn_video_i,
  input  logic [VIDEO_WIDTH-1:0] blu_video_i,
  output logic                   Hsync_o,
  output logic                   Vsync_o,
  output logic                   de_o,
  output logic [VIDEO_WIDTH-1:0] red_video_o,
  output logic [VIDEO_WIDTH-1:0] grn_video_o,
  output logic [VIDEO_WIDTH-1:0] blu_video_o,
  output logic                   frame_start_o
);

  localparam int TOTAL_COLS   = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int TOTAL_ROWS   = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int H_SYNC_START = ACTIVE_COLS + H_FRONT_PORCH;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = ACTIVE_ROWS + V_FRONT_PORCH;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

  // Flags are stored as "in region" booleans; zero is the blank/inactive state.
  typedef struct packed {
    logic frame_start;
    logic active;
    logic vsync;
    logic hsync;
  } flags_t;

  logic [CNT_WIDTH-1:0] col_reg, row_reg;
  logic                 col_wrap, row_last;
  flags_t               decoded, tap;

  assign col_wrap = (col_reg == CNT_WIDTH'(TOTAL_COLS - 1));
  assign row_last = (row_reg == CNT_WIDTH'(TOTAL_ROWS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (col_wrap) begin
      col_reg <= '0;
      row_reg <= row_last ? '0 : row_reg + 1'b1;
    end else begin
      col_reg <= col_reg + 1'b1;
    end
  end

  always_comb begin
    decoded             = '0;
    decoded.hsync       = (col_reg >= CNT_WIDTH'(H_SYNC_START)) && (col_reg < CNT_WIDTH'(H_SYNC_END));
    decoded.vsync       = (row_reg >= CNT_WIDTH'(V_SYNC_START)) && (row_reg < CNT_WIDTH'(V_SYNC_END));
    decoded.active      = (col_reg < CNT_WIDTH'(ACTIVE_COLS)) && (row_reg < CNT_WIDTH'(ACTIVE_ROWS));
    decoded.frame_start = (col_reg == '0) && (row_reg == '0);
  end

  // Delay the decoded flags to match the pixel source latency.
  generate
    if (VIDEO_DELAY == 0) begin : g_no_pipe
      assign tap = decoded;
    end else begin : g_pipe
      flags_t pipe_reg [VIDEO_DELAY];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < VIDEO_DELAY; i++) pipe_reg[i] <= '0;
        end else begin
          pipe_reg[0] <= decoded;
          for (int i = 1; i < VIDEO_DELAY; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end
      assign tap = pipe_reg[VIDEO_DELAY-1];
    end
  endgenerate

  logic                   hsync_reg, vsync_reg, de_reg, frame_start_reg;
  logic [VIDEO_WIDTH-1:0] red_reg, grn_reg, blu_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_reg       <= SYNC_IDLE;
      vsync_reg       <= SYNC_IDLE;
      de_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
      red_reg         <= '0;
      grn_reg         <= '0;
      blu_reg         <= '0;
    end else begin
      hsync_reg       <= tap.hsync ? ~SYNC_IDLE : SYNC_IDLE;
      vsync_reg       <= tap.vsync ? ~SYNC_IDLE : SYNC_IDLE;
      de_reg          <= tap.active;
      frame_start_reg <= tap.frame_start;
      red_reg         <= tap.active ? red_video_i : '0;
      grn_reg         <= tap.active ? grn_video_i : '0;
      blu_reg         <= tap.active ? blu_video_i : '0;
    end
  end

  assign col_o         = col_reg;
  assign row_o         = row_reg;
  assign Hsync_o       = hsync_reg;
  assign Vsync_o       = vsync_reg;
  assign de_o          = de_reg;
  assign frame_start_o = frame_start_reg;
  assign red_video_o   = red_reg;
  assign grn_video_o   = grn_reg;
  assign blu_video_o   = blu_reg;

endmodule

// File: tb/tb_vga_sync_porch_gen.sv
// Directed bench for vga_sync_porch_gen on a reduced 15x8 raster:
// instance a uses VIDEO_DELAY=2 with active-low syncs, instance b VIDEO_DELAY=0 with active-high syncs.
module tb_vga_sync_porch_gen;

  // H: active 0-7, FP 8-9, sync 10-12, BP 13-14. V: active 0-3, FP 4, sync 5-6, BP 7.
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vmode = 1'b0;
  logic [3:0] col_a, row_a, col_b, row_b;
  logic [3:0] hist1 = '0, hist2 = '0;
  logic [2:0] red_ai, grn_ai, blu_ai;
  logic [2:0] red_ao, grn_ao, blu_ao, red_bo, grn_bo, blu_bo;
  logic       hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  int         total = 0;
  int         fails = 0;
  int         k = 0;

  always #5 clk = ~clk;

  // Source model with two clocks of latency: returns the column requested two cycles earlier.
  always @(posedge clk) begin
    hist1 <= col_a;
    hist2 <= hist1;
  end
  assign red_ai = vmode ? hist2[2:0] : 3'd7;
  assign grn_ai = ~red_ai;
  assign blu_ai = 3'd2;

  vga_sync_porch_gen #(
    .VIDEO_WIDTH(3), .CNT_WIDTH(4),
    .ACTIVE_COLS(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(2),
    .ACTIVE_ROWS(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
    .SYNC_ACTIVE_LOW(1), .VIDEO_DELAY(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .col_o(col_a), .row_o(row_a),
    .red_video_i(red_ai), .grn_video_i(grn_ai), .blu_video_i(blu_ai),
    .Hsync_o(hs_a), .Vsync_o(vs_a), .de_o(de_a),
    .red_video_o(red_ao), .grn_video_o(grn_ao), .blu_video_o(blu_ao),
    .frame_start_o(fs_a)
  );

  vga_sync_porch_gen #(
    .VIDEO_WIDTH(3), .CNT_WIDTH(4),
    .ACTIVE_COLS(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(2),
    .ACTIVE_ROWS(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1),
    .SYNC_ACTIVE_LOW(0), .VIDEO_DELAY(0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .col_o(col_b), .row_o(row_b),
    .red_video_i(3'd5), .grn_video_i(3'd5), .blu_video_i(3'd5),
    .Hsync_o(hs_b), .Vsync_o(vs_b), .de_o(de_b),
    .red_video_o(red_bo), .grn_video_o(grn_bo), .blu_video_o(blu_bo),
    .frame_start_o(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s (edge %0d): observed %0d expected %0d", tag, k, obs, expv);
    end
  endtask

  // Advance to just after edge number target (edges counted from reset release).
  task automatic goto(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_a", col_a, 0);
    chk("rst_row_a", row_a, 0);
    chk("rst_hs_a", hs_a, 1);
    chk("rst_vs_a", vs_a, 1);
    chk("rst_de_a", de_a, 0);
    chk("rst_fs_a", fs_a, 0);
    chk("rst_red_a", red_ao, 0);
    chk("rst_hs_b", hs_b, 0);
    chk("rst_vs_b", vs_b, 0);
    chk("rst_de_b", de_b, 0);
    rst = 1'b0;

    goto(1);
    chk("e1_col_a", col_a, 1);
    chk("e1_fs_a", fs_a, 0);
    chk("e1_de_a", de_a, 0);
    chk("e1_hs_a", hs_a, 1);
    chk("e1_fs_b", fs_b, 1);
    chk("e1_de_b", de_b, 1);
    chk("e1_red_b", red_bo, 5);
    chk("e1_col_b", col_b, 1);
    goto(2);
    chk("e2_fs_a", fs_a, 0);
    chk("e2_fs_b", fs_b, 0);
    chk("e2_de_a", de_a, 0);
    goto(3);
    chk("e3_fs_a", fs_a, 1);
    chk("e3_de_a", de_a, 1);
    chk("e3_red_a", red_ao, 7);
    chk("e3_grn_a", grn_ao, 0);
    chk("e3_blu_a", blu_ao, 2);
    goto(4);
    chk("e4_fs_a", fs_a, 0);
    chk("e4_de_a", de_a, 1);
    goto(9);
    chk("e9_de_b", de_b, 0);
    chk("e9_red_b", red_bo, 0);
    chk("e9_hs_b", hs_b, 0);
    goto(10);
    chk("e10_de_a", de_a, 1);
    chk("e10_red_a", red_ao, 7);
    chk("e10_hs_b", hs_b, 0);
    goto(11);
    chk("e11_de_a", de_a, 0);
    chk("e11_red_a_blank", red_ao, 0);
    chk("e11_hs_b", hs_b, 1);
    goto(12);
    chk("e12_hs_a", hs_a, 1);
    goto(13);
    chk("e13_hs_a", hs_a, 0);
    goto(14);
    chk("e14_col_a", col_a, 14);
    chk("e14_row_a", row_a, 0);
    goto(15);
    chk("e15_col_a", col_a, 0);
    chk("e15_row_a", row_a, 1);
    chk("e15_hs_a", hs_a, 0);
    goto(16);
    chk("e16_hs_a", hs_a, 1);
    chk("e16_hs_b", hs_b, 0);
    goto(48);
    chk("e48_de_a", de_a, 1);
    chk("e48_vs_a", vs_a, 1);
    goto(63);
    chk("e63_de_a", de_a, 0);
    chk("e63_red_a", red_ao, 0);
    goto(75);
    chk("e75_vs_b", vs_b, 0);
    goto(76);
    chk("e76_vs_b", vs_b, 1);
    goto(77);
    chk("e77_vs_a", vs_a, 1);
    goto(78);
    chk("e78_vs_a", vs_a, 0);
    goto(107);
    chk("e107_vs_a", vs_a, 0);
    goto(108);
    chk("e108_vs_a", vs_a, 1);
    chk("e108_de_a", de_a, 0);
    goto(119);
    chk("e119_col_a", col_a, 14);
    chk("e119_row_a", row_a, 7);
    goto(120);
    chk("e120_col_a", col_a, 0);
    chk("e120_row_a", row_a, 0);
    goto(121);
    chk("e121_fs_b", fs_b, 1);
    goto(122);
    chk("e122_fs_a", fs_a, 0);
    goto(123);
    chk("e123_fs_a", fs_a, 1);
    chk("e123_de_a", de_a, 1);
    vmode = 1'b1;
    goto(124);
    chk("e124_red_a", red_ao, 1);
    chk("e124_grn_a", grn_ao, 6);
    goto(127);
    chk("e127_red_a", red_ao, 4);
    chk("e127_grn_a", grn_ao, 3);
    goto(130);
    chk("e130_red_a", red_ao, 7);
    goto(131);
    chk("e131_red_a", red_ao, 0);
    chk("e131_de_a", de_a, 0);

    goto(162);
    chk("e162_col_a", col_a, 12);
    chk("e162_row_a", row_a, 2);
    chk("e162_hs_a", hs_a, 1);
    chk("e162_hs_b", hs_b, 1);
    rst = 1'b1;
    goto(163);
    chk("mrst_col_a", col_a, 0);
    chk("mrst_row_a", row_a, 0);
    chk("mrst_hs_a", hs_a, 1);
    chk("mrst_de_a", de_a, 0);
    chk("mrst_hs_b", hs_b, 0);
    rst = 1'b0;
    goto(164);
    chk("e164_col_a", col_a, 1);
    chk("e164_hs_a", hs_a, 1);
    chk("e164_de_a", de_a, 0);
    chk("e164_fs_b", fs_b, 1);
    goto(165);
    chk("e165_hs_a", hs_a, 1);
    chk("e165_de_a", de_a, 0);
    chk("e165_fs_a", fs_a, 0);
    goto(166);
    chk("e166_fs_a", fs_a, 1);
    chk("e166_de_a", de_a, 1);
    chk("e166_red_a", red_ao, 0);
    goto(167);
    chk("e167_red_a", red_ao, 1);
    chk("e167_fs_a", fs_a, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/vga_sync_porch_gen.md
# vga_sync_porch_gen

Parametrised VGA timing generator and video aligner that succeeds the fixed-porch sync block. It runs its own column and row counters, taking active, front porch, sync and back porch widths as parameters for each axis. It publishes the pixel coordinate being requested from the pattern/video source, then re-times Hsync, Vsync and data-enable by a configurable source latency. Video outside the active area is forced to zero, and a frame-start strobe is produced. It sits between the pattern generators and the VGA pins.

## Interface
- VIDEO_WIDTH, 3: bits per colour channel
- CNT_WIDTH, 10: width of column/row counters; must hold max(TOTAL_COLS, TOTAL_ROWS)-1
- ACTIVE_COLS, 640; H_FRONT_PORCH, 16; H_SYNC, 96; H_BACK_PORCH, 48: horizontal segments in clocks; TOTAL_COLS = sum (800)
- ACTIVE_ROWS, 480; V_FRONT_PORCH, 10; V_SYNC, 2; V_BACK_PORCH, 33: vertical segments in lines; TOTAL_ROWS = sum (525)
- SYNC_ACTIVE_LOW, 1: 1 means sync pulses drive 0; 0 means sync pulses drive 1
- VIDEO_DELAY, 2: clocks from col_o/row_o to the matching pixel on *_video_i; legal range 0..15

- clk_i, in, 1: pixel clock
- rst_i, in, 1: synchronous reset, active-high
- col_o, out, CNT_WIDTH: current column request (counter register)
- row_o, out, CNT_WIDTH: current row request (counter register)
- red_video_i / grn_video_i / blu_video_i, in, VIDEO_WIDTH each: pixel for the coordinate issued VIDEO_DELAY clocks earlier
- Hsync_o, out, 1: horizontal sync, registered
- Vsync_o, out, 1: vertical sync, registered
- de_o, out, 1: high when the output pixel is inside the active area
- red_video_o / grn_video_o / blu_video_o, out, VIDEO_WIDTH each: blanked, aligned video
- frame_start_o, out, 1: one-clock pulse coinciding with output of pixel (0,0)

## Operation
- **Column counter:**
  - Increments every clock.
  - At TOTAL_COLS-1 it wraps to 0.
- **Row counter:**
  - Increments on each column wrap.
  - At TOTAL_ROWS-1 with the column also wrapping, it wraps to 0. Both wrap on the same edge.
- **Horizontal decode:** in H sync when ACTIVE_COLS+H_FRONT_PORCH ≤ col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC.
- **Vertical decode:** in V sync when ACTIVE_ROWS+V_FRONT_PORCH ≤ row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC.
- **Sync levels:**
  - Active level = !SYNC_ACTIVE_LOW.
  - Inactive level = SYNC_ACTIVE_LOW.
- **Data enable:** active = (col < ACTIVE_COLS) && (row < ACTIVE_ROWS).
- **Alignment pipeline:**
  - The decoded hsync, vsync, active and frame-start flags (frame-start true when col==0 && row==0) pass through a VIDEO_DELAY-stage shift register.
  - They are then registered into the outputs.
  - With VIDEO_DELAY=0 the shift register is absent.
- **Video path:**
  - Inputs are registered once.
  - The output equals the input when the delayed active flag is 1, else 0.
- **Vsync:** changes only on the output cycle of a column-0 pixel; no mid-line Vsync edges.
- No arithmetic overflow: the counters compare against constants only, and parameter sums are evaluated at elaboration.

## Timing
- Counter value (c,r) appears on col_o/row_o at cycle t.
- The source drives the pixel for (c,r) at t+VIDEO_DELAY.
- Hsync_o, Vsync_o, de_o, frame_start_o and video_o for (c,r) are all valid at t+VIDEO_DELAY+1.
- **Reset:**
  - While rst_i is high at a clock edge, the counters become 0.
  - Every pipeline stage is loaded with the inactive/blank state.
  - Outputs go to: Hsync_o = Vsync_o = SYNC_ACTIVE_LOW, de_o = 0, frame_start_o = 0, video_o = 0.
- **After rst_i deasserts:**
  - The first clock processes (0,0).
  - The first frame_start_o pulse occurs VIDEO_DELAY+1 clocks after the first non-reset edge.
  - Sync outputs stay inactive until the pipeline carries decoded data; no glitch pulse.
- **Reset mid-frame:** the behaviour is identical. Any partial line or frame is abandoned and timing restarts at (0,0).
- **Frame period:** TOTAL_COLS*TOTAL_ROWS clocks (420000 at defaults). frame_start_o pulses exactly once per frame.

## Test plan
- Reset then run, defaults: col_o counts 0..799 and wraps; row_o increments at each wrap; frame_start_o first pulses 3 clocks after reset release, then every 420000 clocks.
- Hsync check, defaults: Hsync_o = 0 for exactly 96 clocks per line, with its falling edge 656+3 clocks after the line's col_o==0; high otherwise.
- Vsync check, defaults: Vsync_o = 0 for exactly 1600 clocks (rows 490–491), with its edges aligned to column-0 outputs; de_o is 0 on every row ≥480.
- Blanking and latency, VIDEO_DELAY=2:
  - Stimulus: drive video_i = 3'b111 constantly.
  - Required: video_o = 7 only while de_o = 1 (640 clocks per active line), and 0 in porch/sync regions.
  - Drive video_i = col_o[2:0] delayed by 2 clocks; video_o must equal the delayed col_o[2:0] when de_o = 1.
- VIDEO_DELAY=0 with SYNC_ACTIVE_LOW=0: syncs pulse high; all outputs lag col_o by exactly 1 clock.
- Reset mid-frame at row 200, col 300: the next edge gives col_o=0, row_o=0; outputs blank/inactive for 3 clocks, then resume with a frame_start_o pulse.
